// File: rtl/z_sqcsa_arb.sv
// z_sqcsa_arb: round-robin arbiter sharing one square-root carry-select adder among R requesters.
// Latency: accept in cycle T, EXEC in T+1, result valid from T+2 until the result handshake.
// Backpressure: req_ready only in IDLE for the granted requester; a stalled result parks the FSM in HOLD.
//
// Optional feature: define Z_SQCSA_ARB_STAT_EN to add the op_count port (saturating result counter).
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake, at most one ready bit high
//   req_a/req_b/req_cin   per-requester operands, requester i at [i*N +: N]
//   res_valid/res_ready   result handshake
//   res_sum/res_cout      registered adder result
//   res_id                requester that owns the result
//   busy                  FSM is not idle
//   op_count              completed result handshakes (Z_SQCSA_ARB_STAT_EN only)

// z_sqcsa: square-root carry-select adder; stage j is j+2 bits wide, so K stages cover N bits.
// Latency: combinational.
// Backpressure: none, pure datapath.
module z_sqcsa #(
    parameter  int K = 15,
    localparam int N = (K + 1) * (K + 2) / 2 - 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    // carry[j] is the carry into stage j
    logic [K:0] carry;

    assign carry[0] = c_in;

    for (genvar j = 0; j < K; j++) begin : g_stage
        localparam int W = j + 2;
        localparam int O = j * (j + 3) / 2;

        if (j == 0) begin : g_ripple
            // The first block sees the real carry-in directly, so no select is needed.
            assign {carry[1], sum[O +: W]} = {1'b0, a[O +: W]} + {1'b0, b[O +: W]}
                                           + {{W{1'b0}}, c_in};
        end else begin : g_select
            logic [W:0] s0;
            logic [W:0] s1;

            // Both carry-in hypotheses are evaluated in parallel; the incoming
            // carry only drives the final mux, which keeps the critical path short.
            assign s0 = {1'b0, a[O +: W]} + {1'b0, b[O +: W]};
            assign s1 = {1'b0, a[O +: W]} + {1'b0, b[O +: W]} + {{W{1'b0}}, 1'b1};

            assign sum[O +: W]  = carry[j] ? s1[W-1:0] : s0[W-1:0];
            assign carry[j + 1] = carry[j] ? s1[W]     : s0[W];
        end
    end

    assign c_out = carry[K];

endmodule

module z_sqcsa_arb #(
    parameter  int K  = 15,
    parameter  int R  = 4,
    localparam int N  = (K + 1) * (K + 2) / 2 - 1,
    localparam int TW = (R > 4) ? 3 : ((R > 2) ? 2 : 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    input  logic [R-1:0]    req_cin,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_sum,
    output logic            res_cout,
    output logic [TW-1:0]   res_id,
    output logic            busy
`ifdef Z_SQCSA_ARB_STAT_EN
    ,
    output logic [15:0]     op_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
    } opnd_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   ptr_q;
    logic [TW-1:0]   ptr_nxt;
    logic [TW-1:0]   id_q;
    logic [TW-1:0]   gnt_idx;
    logic [TW-1:0]   sel;
    logic            gnt_vld;
    logic            accept;
    opnd_t           opnd_q;
    opnd_t           opnd_d;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or after ptr, wrapping.
    // Walking the offsets from far to near lets the nearest hit win.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sel     = '0;
        for (int k = R - 1; k >= 0; k--) begin
            sel = TW'((int'(ptr_q) + k) % R);
            if (req_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    assign ptr_nxt = (gnt_idx == TW'(R - 1)) ? '0 : gnt_idx + TW'(1);

    // Operands of the winner, captured only on an IDLE accept.
    always_comb begin
        opnd_d.a   = req_a[gnt_idx * N +: N];
        opnd_d.b   = req_b[gnt_idx * N +: N];
        opnd_d.cin = req_cin[gnt_idx];
    end

    // ------------------------------------------------------------------
    // Shared adder: its inputs come straight from the operand registers,
    // so they only move when a new request is accepted.
    // ------------------------------------------------------------------
    z_sqcsa #(
        .K (K)
    ) u_add (
        .a     (opnd_q.a),
        .b     (opnd_q.b),
        .c_in  (opnd_q.cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Ready is masked while reset is asserted so no requester
                // believes it was accepted by a transfer the reset discards.
                if (gnt_vld && rst_n) begin
                    req_ready[gnt_idx] = 1'b1;
                    accept             = 1'b1;
                    state_d            = S_EXEC;
                end
            end
            S_EXEC: begin
                busy    = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointer, operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            opnd_q   <= '0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opnd_q <= opnd_d;
                id_q   <= gnt_idx;
                ptr_q  <= ptr_nxt;
            end
            // The adder has had the whole EXEC cycle to settle.
            if (state_q == S_EXEC) begin
                res_sum  <= add_sum;
                res_cout <= add_cout;
                res_id   <= id_q;
            end
        end
    end

`ifdef Z_SQCSA_ARB_STAT_EN
    // Completed-result counter; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (res_valid && res_ready && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_z_sqcsa_arb.sv
// tb_z_sqcsa_arb: directed bench for z_sqcsa_arb with K=3 (N=9), R=4.
// Latency: accept at T, result checked in HOLD at T+2.
// Backpressure: exercised by holding res_ready low in HOLD.
module tb_z_sqcsa_arb;

    localparam int K  = 3;
    localparam int R  = 4;
    localparam int N  = 9;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*N-1:0]  req_a;
    logic [R*N-1:0]  req_b;
    logic [R-1:0]    req_cin;
    logic            res_valid;
    logic            res_ready;
    logic [N-1:0]    res_sum;
    logic            res_cout;
    logic [TW-1:0]   res_id;
    logic            busy;
`ifdef Z_SQCSA_ARB_STAT_EN
    logic [15:0]     op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z_sqcsa_arb #(
        .K (K),
        .R (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy)
`ifdef Z_SQCSA_ARB_STAT_EN
        ,
        .op_count  (op_count)
`endif
    );

    typedef struct {
        logic [3:0] vld;
        logic [1:0] gnt;
        logic [8:0] a;
        logic [8:0] b;
        logic       cin;
        logic [8:0] sum;
        logic       cout;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The granted lane gets the vector operands; every other lane gets
    // values whose sum differs, so a wrong mux select shows up in res_sum.
    task automatic drive_lanes(input logic [3:0] vld, input logic [1:0] lane,
                               input logic [8:0] a, input logic [8:0] b, input logic cin);
        req_valid = vld;
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = (i == int'(lane)) ? a : (a ^ 9'h0F0);
            req_b[i*N +: N] = b;
            req_cin[i]      = (i == int'(lane)) ? cin : ~cin;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_lanes(v.vld, v.gnt, v.a, v.b, v.cin);
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(4'b0001 << v.gnt));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk({tag, "_exec_busy_vld"}, 32'({busy, res_valid}), 32'h2);
        @(negedge clk);
        chk({tag, "_hold_vld_rdy"}, 32'({res_valid, req_ready}), 32'h10);
        chk({tag, "_sum"}, 32'(res_sum), 32'(v.sum));
        chk({tag, "_cout"}, 32'(res_cout), 32'(v.cout));
        chk({tag, "_id"}, 32'(res_id), 32'(v.gnt));
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, 32'({res_valid, busy}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int            acc_n;
        int            acc_cyc[5];
        logic [3:0]    acc_r[5];
        logic          rose;

        // Pointer starts at 0 after reset; each expected grant follows the
        // pointer advanced to (previous grant + 1) mod 4.
        vt[0] = '{vld: 4'b0100, gnt: 2'd2, a: 9'h0A5, b: 9'h05A, cin: 1'b1, sum: 9'h100, cout: 1'b0};
        vt[1] = '{vld: 4'b0001, gnt: 2'd0, a: 9'h1FF, b: 9'h001, cin: 1'b0, sum: 9'h000, cout: 1'b1};
        vt[2] = '{vld: 4'b1111, gnt: 2'd1, a: 9'h123, b: 9'h0AB, cin: 1'b0, sum: 9'h1CE, cout: 1'b0};
        vt[3] = '{vld: 4'b1001, gnt: 2'd3, a: 9'h1AA, b: 9'h155, cin: 1'b1, sum: 9'h100, cout: 1'b1};
        vt[4] = '{vld: 4'b1010, gnt: 2'd1, a: 9'h0FF, b: 9'h0FF, cin: 1'b1, sum: 9'h1FF, cout: 1'b0};
        vt[5] = '{vld: 4'b0011, gnt: 2'd0, a: 9'h1FF, b: 9'h1FF, cin: 1'b1, sum: 9'h1FF, cout: 1'b1};
        vt[6] = '{vld: 4'b0001, gnt: 2'd0, a: 9'h000, b: 9'h000, cin: 1'b0, sum: 9'h000, cout: 1'b0};
        vt[7] = '{vld: 4'b1110, gnt: 2'd1, a: 9'h0F0, b: 9'h00F, cin: 1'b1, sum: 9'h100, cout: 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        res_ready = 1'b0;

        // Reset state, with requests pending while reset is held.
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_rdy_masked", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rst_outputs", 32'({res_valid, busy, res_cout, res_id}), 32'h0);
        chk("rst_sum", 32'(res_sum), 32'h0);
        rst_n = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Round robin with all requesters valid and res_ready tied high.
        do_reset();
        drive_lanes(4'b1111, 2'd0, 9'h011, 9'h022, 1'b0);
        res_ready = 1'b1;
        acc_n = 0;
        for (int c = 0; c < 40 && acc_n < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                acc_r[acc_n]   = req_ready;
                acc_cyc[acc_n] = c;
                acc_n++;
            end
            if (acc_n < 5) @(negedge clk);
        end
        req_valid = '0;
        chk("rr_accept_count", 32'(acc_n), 32'd5);
        for (int k = 0; k < acc_n; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(acc_r[k]), 32'(4'b0001 << (k % 4)));
            if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        res_ready = 1'b0;

        // Backpressure: result held for 5 cycles with new requests pending.
        do_reset();
        drive_lanes(4'b1111, 2'd0, 9'h03C, 9'h0C3, 1'b1);
        #1;
        chk("bp_rdy", 32'(req_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_sum", 32'(res_sum), 32'h100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_stall%0d", c),
                32'({res_valid, req_ready, res_cout, res_id, res_sum}), 32'({1'b1, 4'b0, 1'b0, 2'd0, 9'h100}));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_next_grant", 32'({res_valid, req_ready}), 32'h02);
        req_valid = '0;

        // Reset during EXEC discards the request.
        @(negedge clk);
        drive_lanes(4'b1000, 2'd3, 9'h011, 9'h022, 1'b0);
        #1;
        chk("rex_rdy", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("rex_in_exec", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rex_outputs", 32'({res_valid, busy, res_cout, res_id, req_ready}), 32'h0);
        chk("rex_sum", 32'(res_sum), 32'h0);
        rose = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (res_valid) rose = 1'b1;
        end
        chk("rex_no_result", 32'(rose), 32'h0);
        drive_lanes(4'b1111, 2'd0, 9'h001, 9'h002, 1'b0);
        #1;
        chk("rex_ptr_zero", 32'(req_ready), 32'h1);
        req_valid = '0;

`ifdef Z_SQCSA_ARB_STAT_EN
        do_reset();
        #1;
        chk("stat_reset", 32'(op_count), 32'h0);
        for (int i = 0; i < 3; i++) begin
            run_vec(vt[i], $sformatf("stat%0d", i));
        end
        chk("stat_three", 32'(op_count), 32'd3);
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count;
        run_vec(vt[3], "stat_sat_op");
        chk("stat_saturate", 32'(op_count), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z_sqcsa_arb.md
# z_sqcsa_arb

Round-robin arbiter and sequencer that shares one square-root carry-select adder (`z_sqcsa`) between R requesters. Each requester submits an operand pair and a carry-in over a valid/ready handshake. The block registers the granted operands and drives them into the single shared adder for one full evaluation cycle. It then returns the registered sum, carry-out and requester ID over a valid/ready result port. It sits between the datapath clients and the adder, and is the only path by which clients reach the adder.

## Interface
Parameters:
- `K`, 15, number of adder stages; passed to `z_sqcsa`.
- `N`, (K+1)*(K+2)/2-1, operand width; derived, never overridden.
- `R`, 4, number of requesters; legal range 2..8.
- `TW`, 3 when R>4, 2 when R in 3..4, 1 when R=2, ID width.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in R: per-requester request valid.
- `req_ready` out R: per-requester accept; at most one bit high.
- `req_a` in R*N: operand A; requester i occupies bits [i*N +: N].
- `req_b` in R*N: operand B; same packing as `req_a`.
- `req_cin` in R: per-requester carry-in.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_sum` out N: registered sum.
- `res_cout` out 1: registered carry-out.
- `res_id` out TW: index of the requester that owns the result.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 16: present only with `Z_SQCSA_ARB_STAT_EN`.

## Operation
- FSM states: IDLE, EXEC, HOLD. Reset state is IDLE.
- Round-robin pointer `ptr` (TW bits), reset value 0.
- Grant `g` is the first i with `req_valid[i]=1`, searching `ptr, ptr+1, …, R-1, 0, …, ptr-1`.
- IDLE:
  - `req_ready[g]=1` combinationally when any `req_valid` is high; all other ready bits are 0.
  - On accept: capture `req_a`/`req_b`/`req_cin` of g into operand registers and g into `id_q`.
  - On accept: set `ptr` to (g+1) mod R; go to EXEC.
  - With no valid request: remain in IDLE.
- EXEC:
  - Operand registers drive the adder.
  - At the end of the cycle, register the adder `sum`/`c_out` into `res_sum`/`res_cout` and `id_q` into `res_id`.
  - Go to HOLD.
  - `req_ready` is all 0.
- HOLD:
  - `res_valid=1`.
  - When `res_ready=1`: go to IDLE; `res_valid` drops the next cycle.
  - When `res_ready=0`: hold all result outputs stable.
  - `req_ready` is all 0.
- The adder inputs change only on an IDLE accept. The adder is never presented two requests in one cycle.
- No arithmetic is done outside the adder. Width is N in and N out, with carry-out separate; no truncation.
- A requester may drop `req_valid` before it is granted. No grant is issued to a bit that is low in the accept cycle.
- A request whose `req_valid` stays high is granted within R accepts; this is the starvation bound.

## Timing
- Accept in cycle T. `res_valid` is high from T+2 until the `res_ready` handshake.
- Best-case throughput is one operation per 3 cycles, with `res_ready` tied to 1.
- `busy` is high in EXEC and HOLD.
- Reset values:
  - `req_ready=0`, `res_valid=0`, `res_sum=0`, `res_cout=0`, `res_id=0`, `busy=0`, `ptr=0`.
  - Operand registers are 0; `op_count=0`.
- Reset asserted mid-operation (EXEC or HOLD):
  - The in-flight request is discarded with no result.
  - All outputs take their reset values on the next edge.
- `res_ready` high outside HOLD is ignored.
- Simultaneous `req_valid` from all requesters: the pointer order decides the grant.

## Configuration
- `Z_SQCSA_ARB_STAT_EN` defined:
  - `op_count` is a 16-bit counter that increments on every result handshake (`res_valid` & `res_ready`).
  - It saturates at 0xFFFF and clears on reset.
- `Z_SQCSA_ARB_STAT_EN` undefined: the `op_count` port and the counter logic are absent.

## Test plan
All scenarios use K=3 (N=9) and R=4.
- Single request:
  - Stimulus: requester 2 sends a=0x0A5, b=0x05A, cin=1.
  - Response: `req_ready[2]` high in the accept cycle; after 2 cycles `res_sum=0x100`, `res_cout=0`, `res_id=2`.
- Carry-out:
  - Stimulus: requester 0 sends a=0x1FF, b=0x001, cin=0.
  - Response: `res_sum=0x000`, `res_cout=1`, `res_id=0`.
- Round robin:
  - Stimulus: all four `req_valid` held high, `res_ready=1`.
  - Response: grant order 0,1,2,3,0; one accept every 3 cycles; `ptr` wraps from 3 to 0.
- Backpressure:
  - Stimulus: `res_ready=0` for 5 cycles in HOLD, with new requests pending.
  - Response: outputs stay stable; `req_ready` stays 0.
  - Then `res_ready=1`: IDLE follows and the next grant occurs.
- Reset in EXEC:
  - Stimulus: `rst_n=0` for 1 cycle during EXEC.
  - Response: `res_valid` never rises for that request; all outputs are 0; the next grant starts at requester 0.
- Statistics (with `Z_SQCSA_ARB_STAT_EN`):
  - Stimulus: 3 completed handshakes.
  - Response: `op_count=3`.
  - Stimulus: force the count to 0xFFFF, then one more handshake.
  - Response: `op_count` stays at 0xFFFF.
